// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : Data-memory responder for the single-cycle core. Word RAM
//                plus a memory-mapped I/O page holding a free-running cycle
//                counter, a byte console FIFO with a valid/ready drain port
//                and a status register. Loads are combinational; stores
//                commit on the rising edge.
//                Optional feature macro: DMEM_CONSOLE_EN (console FIFO
//                present when defined; absent by default).
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem #(
    parameter int DEPTH     = 256,
    parameter int CON_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read_address,
    input  logic [31:0] write_address,
    input  logic [31:0] write_data,
    input  logic        mem_write,
    output logic [31:0] read_data,
    output logic [7:0]  con_data,
    output logic        con_valid,
    input  logic        con_ready,
    output logic        addr_err
);

    localparam int          c_AW           = $clog2(DEPTH);
    localparam logic [31:0] c_ADDR_CYCLE   = 32'hFFFF_FFF0;
    localparam logic [31:0] c_ADDR_CONSOLE = 32'hFFFF_FFF4;
    localparam logic [31:0] c_ADDR_STATUS  = 32'hFFFF_FFF8;

    // ------------------------------------------------------------------
    // Address decode (full 32-bit compare)
    // ------------------------------------------------------------------
    logic w_rd_misaligned, w_rd_is_ram, w_rd_is_cycle, w_rd_is_con, w_rd_is_status;
    logic w_wr_misaligned, w_wr_is_ram, w_wr_is_cycle, w_wr_is_con, w_wr_is_status;
    logic w_rd_err, w_wr_err, w_wr_ok;

    assign w_rd_misaligned = (read_address[1:0] != 2'b00);
    assign w_rd_is_ram     = (read_address[31:c_AW+2] == '0);
    assign w_rd_is_cycle   = (read_address == c_ADDR_CYCLE);
    assign w_rd_is_con     = (read_address == c_ADDR_CONSOLE);
    assign w_rd_is_status  = (read_address == c_ADDR_STATUS);

    assign w_wr_misaligned = (write_address[1:0] != 2'b00);
    assign w_wr_is_ram     = (write_address[31:c_AW+2] == '0);
    assign w_wr_is_cycle   = (write_address == c_ADDR_CYCLE);
    assign w_wr_is_con     = (write_address == c_ADDR_CONSOLE);
    assign w_wr_is_status  = (write_address == c_ADDR_STATUS);

    // The CONSOLE address stays mapped even without the FIFO, so stores
    // there are silently dropped rather than flagged.
    assign w_rd_err = w_rd_misaligned |
                      ~(w_rd_is_ram | w_rd_is_cycle | w_rd_is_con | w_rd_is_status);
    assign w_wr_err = mem_write & (w_wr_misaligned |
                      ~(w_wr_is_ram | w_wr_is_cycle | w_wr_is_con | w_wr_is_status));

    // A store takes effect only when aligned and outside reset; unmapped
    // addresses are excluded by each target's own decode term.
    assign w_wr_ok = mem_write & ~w_wr_misaligned & ~reset;

    // ------------------------------------------------------------------
    // RAM
    // ------------------------------------------------------------------
    logic [31:0] r_ram [DEPTH];

    // Word write; contents survive reset, but a store during reset is dropped.
    always_ff @(posedge clk) begin
        if (w_wr_ok && w_wr_is_ram) begin
            r_ram[write_address[c_AW+1:2]] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Cycle counter
    // ------------------------------------------------------------------
    logic [31:0] r_cycle;

    // Free-running counter, reloadable by a store.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cycle <= 32'd0;
        end else if (w_wr_ok && w_wr_is_cycle) begin
            r_cycle <= write_data;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Sticky address-error flag (write-1-to-clear wins over a same-cycle set)
    // ------------------------------------------------------------------
    logic r_addr_err;
    logic w_clr_err;

    assign w_clr_err = w_wr_ok & w_wr_is_status & write_data[17];

    // Accumulate load/store errors until software clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= (r_addr_err | w_rd_err | w_wr_err) & ~w_clr_err;
        end
    end

    assign addr_err = r_addr_err;

    // ------------------------------------------------------------------
    // Console FIFO
    // ------------------------------------------------------------------
    logic [7:0] w_stat_count;
    logic       w_stat_full;
    logic       w_stat_empty;
    logic       w_stat_ovf;

`ifdef DMEM_CONSOLE_EN
    localparam int              c_PW   = $clog2(CON_DEPTH);
    localparam int              c_CW   = c_PW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(CON_DEPTH);

    logic [7:0]      r_fifo [CON_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;
    logic            w_pop, w_push_req, w_push, w_ovf_set, w_clr_ovf;

    assign w_pop      = (r_count != '0) & con_ready;
    assign w_push_req = w_wr_ok & w_wr_is_con;
    // A full FIFO still accepts a push when a byte leaves in the same cycle.
    assign w_push     = w_push_req & ((r_count != c_FULL) | w_pop);
    assign w_ovf_set  = w_push_req & ~w_push;
    assign w_clr_ovf  = w_wr_ok & w_wr_is_status & write_data[16];

    // FIFO storage; no reset needed because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= write_data[7:0];
        end
    end

    // Pointers, occupancy and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            r_overflow <= (r_overflow | w_ovf_set) & ~w_clr_ovf;
        end
    end

    assign con_valid    = (r_count != '0);
    assign con_data     = con_valid ? r_fifo[r_rd_ptr] : 8'h00;
    assign w_stat_count = {{(8-c_CW){1'b0}}, r_count};
    assign w_stat_full  = (r_count == c_FULL);
    assign w_stat_empty = (r_count == '0);
    assign w_stat_ovf   = r_overflow;
`else
    logic w_unused_con;

    assign w_unused_con = con_ready;
    assign con_valid    = 1'b0;
    assign con_data     = 8'h00;
    assign w_stat_count = 8'h00;
    assign w_stat_full  = 1'b0;
    assign w_stat_empty = 1'b1;
    assign w_stat_ovf   = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Load data mux
    // ------------------------------------------------------------------
    logic [31:0] w_status;

    assign w_status = {14'd0, r_addr_err, w_stat_ovf, 6'd0,
                       w_stat_empty, w_stat_full, w_stat_count};

    // Combinational load path; erroneous or CONSOLE loads return zero.
    always_comb begin
        read_data = 32'd0;
        if (!w_rd_misaligned) begin
            if (w_rd_is_ram) begin
                read_data = r_ram[read_address[c_AW+1:2]];
            end else if (w_rd_is_cycle) begin
                read_data = r_cycle;
            end else if (w_rd_is_status) begin
                read_data = w_status;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem
//  Description : Directed self-checking bench for data_mem (RAM, cycle
//                counter, console FIFO or its absence, status and address
//                error handling, mid-operation reset).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem;

    localparam logic [31:0] c_CYCLE   = 32'hFFFF_FFF0;
    localparam logic [31:0] c_CONSOLE = 32'hFFFF_FFF4;
    localparam logic [31:0] c_STATUS  = 32'hFFFF_FFF8;

    logic        clk;
    logic        reset;
    logic [31:0] read_address;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        mem_write;
    logic [31:0] read_data;
    logic [7:0]  con_data;
    logic        con_valid;
    logic        con_ready;
    logic        addr_err;

    int errors = 0;
    int checks = 0;

    data_mem #(
        .DEPTH     (256),
        .CON_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .read_address  (read_address),
        .write_address (write_address),
        .write_data    (write_data),
        .mem_write     (mem_write),
        .read_data     (read_data),
        .con_data      (con_data),
        .con_valid     (con_valid),
        .con_ready     (con_ready),
        .addr_err      (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
        write_address = addr;
        write_data    = data;
        mem_write     = 1'b1;
        tick();
        mem_write     = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL reset_con_valid got=%b exp=0", con_valid); end
        checks++; if (con_data !== 8'h00) begin errors++; $display("FAIL reset_con_data got=%h exp=00", con_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got=%b exp=0", addr_err); end
        read_address = c_STATUS; #1;
        checks++; if (read_data !== 32'h0000_0200) begin errors++; $display("FAIL reset_status got=%h exp=00000200", read_data); end
        read_address = c_CYCLE; #1;
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL reset_cycle got=%h exp=0", read_data); end
    endtask

    task automatic test_cycle();
        read_address = c_CYCLE;
        reset = 1'b0;
        repeat (5) tick();
        checks++; if (read_data !== 32'd5) begin errors++; $display("FAIL cycle_after5 got=%h exp=5", read_data); end
        do_store(c_CYCLE, 32'hFFFF_FFFE);
        checks++; if (read_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL cycle_load got=%h exp=fffffffe", read_data); end
        tick();
        checks++; if (read_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max got=%h exp=ffffffff", read_data); end
        tick();
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL cycle_wrap got=%h exp=0", read_data); end
        read_address = 32'd0;
    endtask

    task automatic test_ram();
        do_store(32'h10, 32'hDEAD_BEEF);
        read_address = 32'h10; #1;
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rt got=%h exp=deadbeef", read_data); end
        do_store(32'h14, 32'h1234_5678);
        read_address  = 32'h14;
        write_address = 32'h14;
        write_data    = 32'hCAFE_F00D;
        mem_write     = 1'b1;
        #1;
        checks++; if (read_data !== 32'h1234_5678) begin errors++; $display("FAIL ram_rw_old got=%h exp=12345678", read_data); end
        tick();
        mem_write = 1'b0;
        checks++; if (read_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL ram_rw_new got=%h exp=cafef00d", read_data); end
        do_store(32'h3FC, 32'hA5A5_0001);
        read_address = 32'h3FC; #1;
        checks++; if (read_data !== 32'hA5A5_0001) begin errors++; $display("FAIL ram_last got=%h exp=a5a50001", read_data); end
        read_address = 32'd0;
        tick();
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL ram_no_err got=%b exp=0", addr_err); end
    endtask

    task automatic test_addr_err();
        read_address = 32'd0;
        do_store(32'h0, 32'h1111_1111);
        do_store(32'h3, 32'h2222_2222);
        #1;
        checks++; if (read_data !== 32'h1111_1111) begin errors++; $display("FAIL mis_store_ram got=%h exp=11111111", read_data); end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mis_store_err got=%b exp=1", addr_err); end
        read_address = c_STATUS; #1;
        checks++; if (read_data !== 32'h0002_0200) begin errors++; $display("FAIL status_err got=%h exp=00020200", read_data); end
        read_address = 32'd0;
        do_store(c_STATUS, 32'h0002_0000);
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", addr_err); end
        read_address = 32'h8000_0000; #1;
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL unmapped_load got=%h exp=0", read_data); end
        tick();
        read_address = 32'd0;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL unmapped_load_err got=%b exp=1", addr_err); end
        // clear and a same-cycle erroneous load: the clear wins
        read_address = 32'h8000_0000;
        do_store(c_STATUS, 32'h0002_0000);
        read_address = 32'd0;
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL clear_wins got=%b exp=0", addr_err); end
        do_store(32'h400, 32'h5);
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL oob_store_err got=%b exp=1", addr_err); end
        read_address = 32'h11; #1;
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL mis_load got=%h exp=0", read_data); end
        read_address = 32'd0;
        do_store(c_STATUS, 32'h0002_0000);
    endtask

    task automatic test_console();
`ifdef DMEM_CONSOLE_EN
        logic [7:0] exp_q [4];
        con_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_store(c_CONSOLE, 32'h41 + i);
        end
        read_address = c_STATUS; #1;
        checks++; if (read_data !== 32'h0001_0104) begin errors++; $display("FAIL con_full_status got=%h exp=00010104", read_data); end
        checks++; if (con_data !== 8'h41) begin errors++; $display("FAIL con_head got=%h exp=41", con_data); end
        con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (con_valid !== 1'b1 || con_data !== 8'(8'h41 + i)) begin errors++; $display("FAIL con_drain%0d got=%b/%h exp=1/%h", i, con_valid, con_data, 8'(8'h41 + i)); end
            tick();
        end
        checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL con_empty got=%b exp=0", con_valid); end
        con_ready = 1'b0;
        do_store(c_STATUS, 32'h0001_0000);
        for (int i = 0; i < 4; i++) begin
            do_store(c_CONSOLE, 32'h50 + i);
        end
        #1;
        checks++; if (read_data !== 32'h0000_0104) begin errors++; $display("FAIL con_refill got=%h exp=00000104", read_data); end
        con_ready = 1'b1;
        do_store(c_CONSOLE, 32'h55);
        con_ready = 1'b0;
        #1;
        checks++; if (read_data !== 32'h0000_0104) begin errors++; $display("FAIL con_push_pop got=%h exp=00000104", read_data); end
        exp_q[0] = 8'h51; exp_q[1] = 8'h52; exp_q[2] = 8'h53; exp_q[3] = 8'h55;
        con_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (con_valid !== 1'b1 || con_data !== exp_q[i]) begin errors++; $display("FAIL con_order%0d got=%b/%h exp=1/%h", i, con_valid, con_data, exp_q[i]); end
            tick();
        end
        con_ready = 1'b0;
        read_address = 32'd0;
`else
        con_ready = 1'b1;
        do_store(c_CONSOLE, 32'h41);
        checks++; if (con_valid !== 1'b0 || con_data !== 8'h00) begin errors++; $display("FAIL con_off_port got=%b/%h exp=0/00", con_valid, con_data); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL con_off_err got=%b exp=0", addr_err); end
        read_address = c_STATUS; #1;
        checks++; if (read_data !== 32'h0000_0200) begin errors++; $display("FAIL con_off_status got=%h exp=00000200", read_data); end
        read_address = c_CONSOLE; #1;
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL con_off_load got=%h exp=0", read_data); end
        con_ready = 1'b0;
        read_address = 32'd0;
`endif
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp_stat;
`ifdef DMEM_CONSOLE_EN
        exp_stat = 32'h0002_0003;
`else
        exp_stat = 32'h0002_0200;
`endif
        con_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_store(c_CONSOLE, 32'h60 + i);
        end
        read_address = 32'h8000_0000;
        tick();
        read_address = c_STATUS; #1;
        checks++; if (read_data !== exp_stat) begin errors++; $display("FAIL pre_reset_status got=%h exp=%h", read_data, exp_stat); end
        reset         = 1'b1;
        write_address = 32'h10;
        write_data    = 32'h0000_0BAD;
        mem_write     = 1'b1;
        tick();
        reset     = 1'b0;
        mem_write = 1'b0;
        checks++; if (con_valid !== 1'b0) begin errors++; $display("FAIL mr_con_valid got=%b exp=0", con_valid); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mr_addr_err got=%b exp=0", addr_err); end
        #1;
        checks++; if (read_data !== 32'h0000_0200) begin errors++; $display("FAIL mr_status got=%h exp=00000200", read_data); end
        read_address = c_CYCLE; #1;
        checks++; if (read_data !== 32'd0) begin errors++; $display("FAIL mr_cycle got=%h exp=0", read_data); end
        read_address = 32'h10; #1;
        checks++; if (read_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mr_ram got=%h exp=deadbeef", read_data); end
        read_address = 32'd0;
    endtask

    initial begin
        reset         = 1'b1;
        read_address  = 32'd0;
        write_address = 32'd0;
        write_data    = 32'd0;
        mem_write     = 1'b0;
        con_ready     = 1'b0;
        test_reset();
        test_cycle();
        test_ram();
        test_addr_err();
        test_console();
        test_mid_reset();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
